// File: rtl/seven_seg_scanner_if.sv
// Bus between the segment decode stage and the two-digit seven-segment scanner.
// Brightness exists only when SEVEN_SEG_SCANNER_DIM_EN is defined.
interface seven_seg_scanner_if;
  logic [7:0] SevenSegDig1;
  logic [7:0] SevenSegDig2;
  logic       Load;
  logic       Blank;
  logic [7:0] SegOut;
  logic [1:0] DigitEn;
  logic       Pending;
  logic       FrameTick;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
  logic [3:0] Brightness;
`endif

  modport master (
    output SevenSegDig1, SevenSegDig2, Load, Blank,
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    output Brightness,
`endif
    input  SegOut, DigitEn, Pending, FrameTick
  );

  modport slave (
    input  SevenSegDig1, SevenSegDig2, Load, Blank,
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    input  Brightness,
`endif
    output SegOut, DigitEn, Pending, FrameTick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Two-digit time-multiplexed seven-segment scanner with dead-time gaps and
// frame-aligned double buffering. Optional dimming via SEVEN_SEG_SCANNER_DIM_EN.
module seven_seg_scanner #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic Clock,
  input  logic Reset,
  seven_seg_scanner_if.slave bus
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {GAP2, SHOW1, GAP1, SHOW2} state_t;

  state_t        state, state_next;
  logic [CW-1:0] slot, slot_next;
  logic [7:0]    shadow1, shadow2, active1, active2;
  logic          pending;
  logic          lit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= GAP2;
      slot    <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
      active1 <= '0;
      active2 <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_next;
      slot  <= slot_next;
      // GAP2 exit is the only point active changes; a load on that edge bypasses shadow.
      if (state == GAP2) begin
        if (bus.Load) begin
          active1 <= bus.SevenSegDig1;
          active2 <= bus.SevenSegDig2;
        end else if (pending) begin
          active1 <= shadow1;
          active2 <= shadow2;
        end
        pending <= 1'b0;
      end else if (bus.Load) begin
        shadow1 <= bus.SevenSegDig1;
        shadow2 <= bus.SevenSegDig2;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    slot_next  = slot + 1'b1;
    case (state)
      GAP2:    state_next = SHOW1;
      SHOW1:   if (slot == SLOT_LAST) state_next = GAP1;
      GAP1:    state_next = SHOW2;
      SHOW2:   if (slot == SLOT_LAST) state_next = GAP2;
      default: state_next = GAP2;
    endcase
    if (state_next != state) slot_next = '0;
  end

`ifdef SEVEN_SEG_SCANNER_DIM_EN
  assign lit = (32'(slot) < 32'(bus.Brightness));
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    bus.SegOut    = '0;
    bus.DigitEn   = '0;
    bus.FrameTick = (state == GAP2);
    bus.Pending   = pending;
    if (!bus.Blank && lit) begin
      case (state)
        SHOW1: begin
          bus.DigitEn = 2'b01;
          bus.SegOut  = active1;
        end
        SHOW2: begin
          bus.DigitEn = 2'b10;
          bus.SegOut  = active2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a frame-phase reference model pushes
// expected outputs to a scoreboard queue that is popped and compared each cycle.
module tb_seven_seg_scanner;

  localparam int unsigned P = 8;
  localparam int unsigned F = 2 * P + 2;

  typedef struct packed {
    logic [1:0] en;
    logic [7:0] seg;
    logic       pend;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_scanner_if sif ();

  seven_seg_scanner #(.PRESCALE(P)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (sif)
  );

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Model: phase 0 = GAP2, 1..P = SHOW1, P+1 = GAP1, P+2..2P+1 = SHOW2
  int unsigned ph = 0;
  logic [7:0]  sh1 = '0, sh2 = '0, ac1 = '0, ac2 = '0;
  logic        pend = 1'b0;
  int          ticks;

  function automatic logic lit_model(int unsigned slot);
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    return slot < int'(sif.Brightness);
`else
    return (slot < P);
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.tick = (ph == 0);
    e.pend = pend;
    e.en   = 2'b00;
    e.seg  = 8'h00;
    if (!sif.Blank) begin
      if (ph >= 1 && ph <= P) begin
        if (lit_model(ph - 1)) begin
          e.en  = 2'b01;
          e.seg = ac1;
        end
      end else if (ph >= P + 2) begin
        if (lit_model(ph - P - 2)) begin
          e.en  = 2'b10;
          e.seg = ac2;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      ph = 0; sh1 = '0; sh2 = '0; ac1 = '0; ac2 = '0; pend = 1'b0;
    end else begin
      if (ph == 0) begin
        if (sif.Load) begin
          ac1 = sif.SevenSegDig1;
          ac2 = sif.SevenSegDig2;
        end else if (pend) begin
          ac1 = sh1;
          ac2 = sh2;
        end
        pend = 1'b0;
      end else if (sif.Load) begin
        sh1  = sif.SevenSegDig1;
        sh2  = sif.SevenSegDig2;
        pend = 1'b1;
      end
      ph = (ph + 1) % F;
    end
    #1;
    sb.push_back(model_out());
    e = sb.pop_front();
    chk("digit_en",   {6'b0, sif.DigitEn},   {6'b0, e.en});
    chk("seg_out",    sif.SegOut,            e.seg);
    chk("pending",    {7'b0, sif.Pending},   {7'b0, e.pend});
    chk("frame_tick", {7'b0, sif.FrameTick}, {7'b0, e.tick});
    chk("onehot_en",  {7'b0, &sif.DigitEn},  8'h00);
    if (sif.FrameTick === 1'b1) ticks++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int unsigned target);
    for (int unsigned i = 0; i <= F && ph != target; i++) step();
  endtask

  task automatic load_once(input logic [7:0] d1, input logic [7:0] d2);
    sif.SevenSegDig1 = d1;
    sif.SevenSegDig2 = d2;
    sif.Load = 1'b1;
    step();
    sif.Load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sif.Load = 1'b0;
    sif.Blank = 1'b0;
    sif.SevenSegDig1 = '0;
    sif.SevenSegDig2 = '0;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    sif.Brightness = 4'd15;
`endif
    run(3);

    // First cycle after reset: load goes straight to active through the GAP2 bypass
    rst = 1'b0;
    load_once(8'b0111_0111, 8'b0000_0110);
    run(F - 1);
    ticks = 0;
    run(F);
    chk("ticks_per_frame", 8'(ticks), 8'd1);
    run(F);

    // Load mid-SHOW1 held in shadow until the frame boundary
    wait_phase(3);
    load_once(8'hA1, 8'hA1);
    run(2 * F);
    wait_phase(4);
    load_once(8'h3F, 8'h06);
    run(2 * F);

    // Two loads in one frame: last one wins
    wait_phase(2);
    load_once(8'h5B, 8'h06);
    wait_phase(11);
    load_once(8'h4F, 8'h06);
    run(2 * F);

    // Load during GAP2: immediate display, Pending never set
    wait_phase(0);
    load_once(8'h12, 8'h34);
    run(F);

    // Blank mid-SHOW2 for 5 cycles
    wait_phase(12);
    sif.Blank = 1'b1;
    run(5);
    sif.Blank = 1'b0;
    run(F);

    // Reset mid-frame with a load still pending
    wait_phase(3);
    load_once(8'h66, 8'h77);
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2 * F);
    load_once(8'h6D, 8'h7D);
    run(2 * F);

`ifdef SEVEN_SEG_SCANNER_DIM_EN
    wait_phase(0);
    sif.Brightness = 4'd3;
    run(F);
    sif.Brightness = 4'd0;
    run(F);
    sif.Brightness = 4'd15;
    run(F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
